// File: rtl/uart_alu_ctrl_if.sv
// rtl/uart_alu_ctrl_if.sv - receiver, ALU and transmitter signals seen by the command sequencer
interface uart_alu_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 6
);
    logic [DATA_WIDTH-1:0] i_rx_data;
    logic                  i_rx_done;
    logic [DATA_WIDTH-1:0] i_alu_result;
    logic                  i_tx_done;
    logic [DATA_WIDTH-1:0] o_alu_a;
    logic [DATA_WIDTH-1:0] o_alu_b;
    logic [OP_WIDTH-1:0]   o_alu_op;
    logic [DATA_WIDTH-1:0] o_tx_data;
    logic                  o_tx_start;
    logic                  o_busy;
    logic                  o_timeout;
    logic                  o_overrun;

    // Sequencer side
    modport slave (
        input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        output o_alu_a, o_alu_b, o_alu_op, o_tx_data,
        output o_tx_start, o_busy, o_timeout, o_overrun
    );

    // Surrounding UART/ALU side
    modport master (
        output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        input  o_alu_a, o_alu_b, o_alu_op, o_tx_data,
        input  o_tx_start, o_busy, o_timeout, o_overrun
    );
endinterface

// File: rtl/uart_alu_ctrl.sv
// rtl/uart_alu_ctrl.sv - collects A, B, opcode bytes, runs the ALU and sends the result byte
module uart_alu_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int OP_WIDTH       = 6,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TIMEOUT_WIDTH  = 20
) (
    input  logic           i_clk,
    input  logic           i_reset,
    uart_alu_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                   state, state_nx;
    logic [TIMEOUT_WIDTH-1:0] cnt, cnt_nx;
    logic [DATA_WIDTH-1:0]    alu_a_nx, alu_b_nx, tx_data_nx;
    logic [OP_WIDTH-1:0]      alu_op_nx;
    logic                     tx_start_nx, busy_nx, timeout_nx, overrun_nx;

    // Next-state, counter and next-output decode; every output is registered below
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        alu_a_nx    = bus.o_alu_a;
        alu_b_nx    = bus.o_alu_b;
        alu_op_nx   = bus.o_alu_op;
        tx_data_nx  = bus.o_tx_data;
        tx_start_nx = 1'b0;
        timeout_nx  = 1'b0;
        overrun_nx  = 1'b0;
        case (state)
            ST_WAIT_A: begin
                cnt_nx = '0;
                if (bus.i_rx_done) begin
                    alu_a_nx = bus.i_rx_data;
                    state_nx = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                // A byte arriving on the expiry cycle still wins over the timeout
                if (bus.i_rx_done) begin
                    alu_b_nx = bus.i_rx_data;
                    cnt_nx   = '0;
                    state_nx = ST_WAIT_OP;
                end else if (cnt == TIMEOUT_LAST) begin
                    timeout_nx = 1'b1;
                    cnt_nx     = '0;
                    state_nx   = ST_WAIT_A;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_WAIT_OP: begin
                if (bus.i_rx_done) begin
                    alu_op_nx = bus.i_rx_data[OP_WIDTH-1:0];
                    cnt_nx    = '0;
                    state_nx  = ST_EXEC;
                end else if (cnt == TIMEOUT_LAST) begin
                    timeout_nx = 1'b1;
                    cnt_nx     = '0;
                    state_nx   = ST_WAIT_A;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_EXEC: begin
                overrun_nx = bus.i_rx_done;
                tx_data_nx = bus.i_alu_result;
                state_nx   = ST_SEND;
            end
            ST_SEND: begin
                overrun_nx  = bus.i_rx_done;
                tx_start_nx = 1'b1;
                state_nx    = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                overrun_nx = bus.i_rx_done;
                // o_tx_start is high exactly during the first ST_WAIT_TX cycle, so it
                // masks a done flag still left over from the previous frame
                if (bus.i_tx_done && !bus.o_tx_start) begin
                    state_nx = ST_WAIT_A;
                end
            end
            default: begin
                state_nx = ST_WAIT_A;
                cnt_nx   = '0;
            end
        endcase
        busy_nx = (state_nx == ST_EXEC) || (state_nx == ST_SEND) || (state_nx == ST_WAIT_TX);
    end

    // State, counter and output registers; reset clears everything at once
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state          <= ST_WAIT_A;
            cnt            <= '0;
            bus.o_alu_a    <= '0;
            bus.o_alu_b    <= '0;
            bus.o_alu_op   <= '0;
            bus.o_tx_data  <= '0;
            bus.o_tx_start <= 1'b0;
            bus.o_busy     <= 1'b0;
            bus.o_timeout  <= 1'b0;
            bus.o_overrun  <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            bus.o_alu_a    <= alu_a_nx;
            bus.o_alu_b    <= alu_b_nx;
            bus.o_alu_op   <= alu_op_nx;
            bus.o_tx_data  <= tx_data_nx;
            bus.o_tx_start <= tx_start_nx;
            bus.o_busy     <= busy_nx;
            bus.o_timeout  <= timeout_nx;
            bus.o_overrun  <= overrun_nx;
        end
    end
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb/tb_uart_alu_ctrl.sv - scoreboard bench for the UART/ALU command sequencer
module tb_uart_alu_ctrl;
    localparam int DW = 8;
    localparam int OW = 6;
    localparam int TC = 16;
    localparam int TW = 5;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [OW-1:0] op;
        logic [DW-1:0] res;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   timeout_seen = 0;
    int   overrun_seen = 0;
    exp_t exp_q[$];

    uart_alu_ctrl_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) bus ();

    uart_alu_ctrl #(
        .DATA_WIDTH(DW), .OP_WIDTH(OW), .TIMEOUT_CYCLES(TC), .TIMEOUT_WIDTH(TW)
    ) dut (
        .i_clk(clk),
        .i_reset(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [OW-1:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            default: return a ^ b;
        endcase
    endfunction

    assign bus.i_alu_result = alu_ref(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

    always @(posedge clk) begin
        if (bus.o_timeout) timeout_seen <= timeout_seen + 1;
        if (bus.o_overrun) overrun_seen <= overrun_seen + 1;
    end

    task automatic send_byte(input logic [DW-1:0] b);
        @(negedge clk);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        @(negedge clk);
        bus.i_rx_done = 1'b0;
    endtask

    task automatic expect_cmd(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] opb);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.op  = opb[OW-1:0];
        e.res = alu_ref(a, b, opb[OW-1:0]);
        exp_q.push_back(e);
    endtask

    task automatic send_cmd(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] opb);
        expect_cmd(a, b, opb);
        send_byte(a);
        send_byte(b);
        send_byte(opb);
    endtask

    // Called right after the opcode byte; returns at the negedge where o_tx_start is seen
    task automatic wait_result();
        exp_t e;
        int   n;
        bit   seen;
        seen = 0;
        for (n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (bus.o_tx_start) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL tx_start_wait: no o_tx_start within 10 cycles");
            return;
        end
        checks++;
        if (n + 1 !== 3) begin
            errors++;
            $display("FAIL latency: got %0d edges, want 3", n + 1);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: unexpected result 0x%0h", bus.o_tx_data);
            return;
        end
        e = exp_q.pop_front();
        if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_data} !== {e.a, e.b, e.op, e.res}) begin
            errors++;
            $display("FAIL result: got a=%0h b=%0h op=%0h tx=%0h, want a=%0h b=%0h op=%0h tx=%0h",
                     bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_data, e.a, e.b, e.op, e.res);
        end
        checks++;
        if (bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_at_start: got %0b want 1", bus.o_busy);
        end
    endtask

    task automatic complete_tx();
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
        checks++;
        if (bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_done: got %0b want 0", bus.o_busy);
        end
    endtask

    task automatic finish_tx();
        @(negedge clk);
        checks++;
        if (bus.o_tx_start !== 1'b0) begin
            errors++;
            $display("FAIL tx_start_width: still %0b one cycle later", bus.o_tx_start);
        end
        complete_tx();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %0h want 0", {bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_data});
        end
        checks++;
        if ({bus.o_tx_start, bus.o_busy, bus.o_timeout, bus.o_overrun} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {bus.o_tx_start, bus.o_busy, bus.o_timeout, bus.o_overrun});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        send_cmd(8'h05, 8'h03, 8'h20);
        wait_result();
        finish_tx();
    endtask

    task automatic test_opmask();
        send_cmd(8'h10, 8'h04, 8'hE2);
        wait_result();
        finish_tx();
    endtask

    task automatic test_timeout();
        int t0;
        int first_at;
        t0 = timeout_seen;
        first_at = 0;
        send_byte(8'h77);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.o_timeout && first_at == 0) first_at = i;
        end
        checks++;
        if (first_at !== TC) begin
            errors++;
            $display("FAIL timeout_cycle: pulse after %0d cycles want %0d", first_at, TC);
        end
        checks++;
        if (timeout_seen - t0 !== 1) begin
            errors++;
            $display("FAIL timeout_count: got %0d pulses want 1", timeout_seen - t0);
        end
        checks++;
        if (bus.o_alu_a !== 8'h77) begin
            errors++;
            $display("FAIL timeout_keep_a: got %0h want 77", bus.o_alu_a);
        end
        send_cmd(8'h01, 8'h02, 8'h20);
        wait_result();
        finish_tx();
    endtask

    task automatic test_race();
        int t0;
        t0 = timeout_seen;
        expect_cmd(8'h40, 8'h09, 8'h20);
        send_byte(8'h40);
        repeat (TC - 1) @(negedge clk);
        bus.i_rx_data = 8'h09;
        bus.i_rx_done = 1'b1;
        @(negedge clk);
        bus.i_rx_done = 1'b0;
        send_byte(8'h20);
        wait_result();
        finish_tx();
        checks++;
        if (timeout_seen - t0 !== 0) begin
            errors++;
            $display("FAIL race_timeout: got %0d pulses want 0", timeout_seen - t0);
        end
    endtask

    task automatic test_overrun();
        int o0;
        o0 = overrun_seen;
        send_cmd(8'h11, 8'h22, 8'h20);
        wait_result();
        bus.i_rx_data = 8'h99;
        bus.i_rx_done = 1'b1;
        @(negedge clk);
        bus.i_rx_done = 1'b0;
        checks++;
        if (bus.o_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_pulse: got %0b want 1", bus.o_overrun);
        end
        checks++;
        if (bus.o_alu_a !== 8'h11) begin
            errors++;
            $display("FAIL overrun_keep_a: got %0h want 11", bus.o_alu_a);
        end
        complete_tx();
        @(negedge clk);
        checks++;
        if (overrun_seen - o0 !== 1) begin
            errors++;
            $display("FAIL overrun_count: got %0d pulses want 1", overrun_seen - o0);
        end
        send_cmd(8'h30, 8'h0F, 8'h22);
        wait_result();
        finish_tx();
    endtask

    task automatic test_stale_done();
        bus.i_tx_done = 1'b1;
        send_cmd(8'h0A, 8'h0B, 8'h20);
        wait_result();
        @(negedge clk);
        checks++;
        if (bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL stale_done_first: busy %0b want 1", bus.o_busy);
        end
        @(negedge clk);
        checks++;
        if (bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL stale_done_second: busy %0b want 0", bus.o_busy);
        end
        bus.i_tx_done = 1'b0;
    endtask

    task automatic test_async_reset();
        bit seen;
        seen = 0;
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h20);
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (bus.o_tx_start) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL async_setup: no o_tx_start within 10 cycles");
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_tx_start, bus.o_busy, bus.o_alu_a} !== '0) begin
            errors++;
            $display("FAIL async_reset: got start=%0b busy=%0b a=%0h want 0", bus.o_tx_start, bus.o_busy, bus.o_alu_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.o_tx_start, bus.o_busy} !== 2'b00) begin
            errors++;
            $display("FAIL after_reset_idle: got start=%0b busy=%0b want 0", bus.o_tx_start, bus.o_busy);
        end
        send_cmd(8'h07, 8'h09, 8'h20);
        wait_result();
        finish_tx();
    endtask

    initial begin
        bus.i_rx_data = '0;
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        test_reset();
        test_basic();
        test_opmask();
        test_timeout();
        test_race();
        test_overrun();
        test_stale_done();
        test_async_reset();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results never seen", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
